// File: rtl/mac_ctrl_pkg.sv
// Shared types for the MAC tile scheduler: FSM state encoding and the
// multiplier-array in_valid mode codes.
package mac_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } sched_state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_A    = 2'b01;
    localparam logic [1:0] MODE_B    = 2'b10;
    localparam logic [1:0] MODE_AB   = 2'b11;

    // The array only sees a mode code while a beat is being issued.
    function automatic logic [1:0] beat_mode(input logic beat, input logic [1:0] mode);
        return beat ? mode : MODE_NONE;
    endfunction

endpackage

// File: rtl/issue_pipe_tracker.sv
// Shadows the multiplier array latency: a DEPTH-stage shift register of issued
// beats whose oldest stage is the accumulate enable.
module issue_pipe_tracker #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic beat,
    output logic acc_en,
    output logic pipe_empty
);

    // Every stage except the output one; those beats are still in flight.
    localparam logic [DEPTH-1:0] PENDING_MASK = {DEPTH{1'b1}} >> 1;

    logic [DEPTH-1:0] shift_reg;
    logic [DEPTH-1:0] shift_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign shift_next[gi] = beat;
            end else begin : g_body
                assign shift_next[gi] = shift_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
        end else begin
            shift_reg <= shift_next;
        end
    end

    assign acc_en = shift_reg[DEPTH-1];

    // A beat sitting in the output stage retires this cycle, so it does not
    // hold the pipe open.
    assign pipe_empty = ((shift_reg & PENDING_MASK) == '0);

endmodule

// File: rtl/mac_tile_scheduler.sv
// Tile-job scheduler: issues K operand beats into the multiplier array, tracks
// them through its latency, then presents the tile result until consumed.
module mac_tile_scheduler
    import mac_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_k_steps,
    input  logic [1:0]       cfg_mode,
    input  logic             op_valid,
    output logic             op_ready,
    output logic             arr_enable,
    output logic [1:0]       arr_in_valid,
    output logic             acc_clear,
    output logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    sched_state_t     state_reg;
    logic [CNT_W-1:0] k_reg;
    logic [CNT_W-1:0] issue_cnt_reg;
    logic [1:0]       mode_reg;
    logic             op_ready_reg;
    logic             busy_reg;
    logic             out_valid_reg;

    logic beat;
    logic last_beat;
    logic pipe_empty;

    assign beat      = op_valid && op_ready_reg;
    // k_reg is never zero outside IDLE, so k_reg-1 cannot underflow here.
    assign last_beat = beat && (issue_cnt_reg == (k_reg - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            k_reg         <= '0;
            issue_cnt_reg <= '0;
            mode_reg      <= MODE_NONE;
            op_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && (cfg_k_steps != '0)) begin
                        k_reg         <= cfg_k_steps;
                        mode_reg      <= cfg_mode;
                        issue_cnt_reg <= '0;
                        op_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (beat) begin
                        issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
                        if (last_beat) begin
                            op_ready_reg <= 1'b0;
                            state_reg    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    issue_pipe_tracker #(
        .DEPTH(MUL_LAT)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .beat      (beat),
        .acc_en    (acc_en),
        .pipe_empty(pipe_empty)
    );

    assign op_ready     = op_ready_reg;
    assign busy         = busy_reg;
    assign out_valid    = out_valid_reg;
    assign arr_enable   = beat;
    assign arr_in_valid = beat_mode(beat, mode_reg);
    assign acc_clear    = beat && (issue_cnt_reg == '0);
    assign done         = (state_reg == ST_OUTPUT) && out_ready;

endmodule

// File: doc/mac_tile_scheduler.md
MAC_TILE_SCHEDULER -- requirements
Module: mac_tile_scheduler

Interface
REQ-001 SHALL have parameter MUL_LAT, default 1: multiplier array latency in cycles, valid range 1..4.
REQ-002 SHALL have parameter CNT_W, default 8: width of the K-step counter.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin a tile job; sampled only in IDLE.
REQ-006 SHALL have port cfg_k_steps, input, CNT_W: number of K-step operand beats in the job.
REQ-007 SHALL have port cfg_mode, input, 2: in_valid code forwarded to the array.
REQ-008 SHALL have port op_valid, input, 1: operand beat available.
REQ-009 SHALL have port op_ready, output, 1: scheduler accepts an operand beat.
REQ-010 SHALL have port arr_enable, output, 1: multiplier array enable.
REQ-011 SHALL have port arr_in_valid, output, 2: multiplier array in_valid.
REQ-012 SHALL have port acc_clear, output, 1: clear the downstream accumulator.
REQ-013 SHALL have port acc_en, output, 1: accumulate the current array output.
REQ-014 SHALL have port out_valid, output, 1: tile result ready.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1: one-cycle pulse at job completion.

Function
REQ-018 SHALL implement the FSM states IDLE, ISSUE, DRAIN and OUTPUT.
REQ-019 In IDLE, start=1 with cfg_k_steps!=0 SHALL latch cfg_k_steps and cfg_mode and move to ISSUE on the next cycle.
REQ-020 In IDLE, start=1 with cfg_k_steps=0 SHALL be ignored: state stays IDLE and no output changes.
REQ-021 In ISSUE, op_ready SHALL be 1; in every other state op_ready SHALL be 0.
REQ-022 A beat SHALL be op_valid and op_ready both high in the same cycle.
REQ-023 Each beat SHALL drive, combinationally in the same cycle, arr_enable=1 and arr_in_valid=latched mode, and SHALL increment the issue counter.
REQ-024 In non-beat cycles, arr_enable and arr_in_valid SHALL be 0.
REQ-025 acc_clear SHALL be 1 only in the cycle of the first beat of a job.
REQ-026 acc_en SHALL equal the beat signal delayed by exactly MUL_LAT cycles; beat gaps SHALL be preserved.
REQ-027 The beat that makes the issue count equal the latched K SHALL cause a transition to DRAIN on the next cycle.
REQ-028 DRAIN SHALL move to OUTPUT when the delay pipeline holds no beats.
REQ-029 out_valid SHALL rise exactly MUL_LAT+1 cycles after the last beat.
REQ-030 In OUTPUT, out_valid SHALL be held at 1 until out_ready=1.
REQ-031 In the out_ready=1 cycle, done SHALL pulse 1 and the state SHALL return to IDLE on the next cycle.
REQ-032 start asserted while busy SHALL be ignored.
REQ-033 The counter SHALL be an unsigned CNT_W-bit counter; K=2^CNT_W-1 SHALL complete without wrap.

Reset
REQ-034 While reset=1 at a clock edge, the state SHALL become IDLE, and the counters, delay pipeline and latched config SHALL be cleared.
REQ-035 After reset, op_ready, arr_enable, arr_in_valid, acc_clear, acc_en, out_valid, busy and done SHALL all be 0.
REQ-036 Reset asserted mid-job SHALL abort the job with no done pulse, and in-flight acc_en SHALL be squashed.

Structure
REQ-037 Package mac_ctrl_pkg SHALL hold the FSM state enum and the in_valid mode constants.
REQ-038 The MUL_LAT-deep beat shift register SHALL be the sub-module issue_pipe_tracker, with outputs acc_en and pipe_empty.

Verification
REQ-039 K=4, MUL_LAT=1, op_valid always 1, out_ready always 1 -> 4 consecutive beats, acc_clear on beat 0, acc_en in cycles t1..t4, out_valid at last beat+2, done 1 cycle, busy falls the next cycle.
REQ-040 K=3 with op_valid pattern 1,0,1,0,1 -> arr_enable mirrors the beats, acc_en is the same pattern delayed MUL_LAT, exactly 3 counted beats.
REQ-041 out_ready held 0 for 5 cycles in OUTPUT -> out_valid stays 1 and done is 0 until out_ready=1, then done pulses once.
REQ-042 start with K=0, and start pulsed during ISSUE -> no state change, no extra beats.
REQ-043 reset asserted after 2 of 6 beats -> next cycle all outputs are 0, state is IDLE, no acc_en and no done; a new start runs a full job normally.
REQ-044 MUL_LAT=3, K=1 -> acc_en 3 cycles after the beat, out_valid 4 cycles after it.
